// File: rtl/axi_lite_slave_if.sv
// AXI4-Lite bus bundle between a bus master and the register slave.
interface axi_lite_slave_if;
  logic [31:0] awaddr;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arcache, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arcache, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_lite_slave.sv
// AXI4-Lite register file: NUM_REGS x 32-bit registers with byte strobes,
// independent AW/W acceptance, concurrent read and write channels.
module axi_lite_slave #(
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                     aclk,
  input  logic                     areset,
  axi_lite_slave_if.slave          bus,
  output logic [NUM_REGS*32-1:0]   regs_out
);
  localparam int unsigned IDX_W       = $clog2(NUM_REGS);
  localparam logic [31:0] SPAN        = 32'(NUM_REGS * 4);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t    w_state, w_state_nx;
  r_state_t    r_state, r_state_nx;
  logic        aw_lat, w_lat;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_hs, w_hs, ar_hs, do_write;
  logic [31:0] w_addr_eff, w_data_eff, w_off, r_off;
  logic [3:0]  w_strb_eff;
  logic        w_in_range, r_in_range;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic [31:0] regs [NUM_REGS];
  logic        unused_sideband;

  assign unused_sideband = ^{bus.awcache, bus.awprot, bus.arcache, bus.arprot};

  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid & bus.wready;
  assign ar_hs = bus.arvalid & bus.arready;

  // A beat latched earlier takes precedence over the live bus value.
  assign w_addr_eff = aw_lat ? aw_addr_q : bus.awaddr;
  assign w_data_eff = w_lat ? w_data_q : bus.wdata;
  assign w_strb_eff = w_lat ? w_strb_q : bus.wstrb;
  assign do_write   = (w_state == W_IDLE) & (aw_lat | aw_hs) & (w_lat | w_hs);

  assign w_off      = w_addr_eff - BASE_ADDR;
  assign w_in_range = w_off < SPAN;
  assign w_idx      = w_off[IDX_W+1:2];
  assign r_off      = bus.araddr - BASE_ADDR;
  assign r_in_range = r_off < SPAN;
  assign r_idx      = r_off[IDX_W+1:2];

  // Write FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_state_nx;
  end

  // Write FSM next state: respond once both halves are in, hold until bready.
  always_comb begin
    w_state_nx = w_state;
    case (w_state)
      W_IDLE: if (do_write) w_state_nx = W_RESP;
      W_RESP: if (bus.bready) w_state_nx = W_IDLE;
    endcase
  end

  // Write FSM outputs: each ready drops once its own beat is latched.
  always_comb begin
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    if (!areset) begin
      case (w_state)
        W_IDLE: begin
          bus.awready = ~aw_lat;
          bus.wready  = ~w_lat;
        end
        W_RESP: bus.bvalid = 1'b1;
      endcase
    end
  end
  assign bus.bresp = bresp_q;

  // AW/W latch flags: set on a lone handshake, cleared when the write fires.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_lat <= 1'b0;
      w_lat  <= 1'b0;
    end else if (do_write) begin
      aw_lat <= 1'b0;
      w_lat  <= 1'b0;
    end else begin
      if (aw_hs) aw_lat <= 1'b1;
      if (w_hs)  w_lat  <= 1'b1;
    end
  end

  // Beat payload capture; only meaningful while the matching flag is set.
  always_ff @(posedge aclk) begin
    if (aw_hs) aw_addr_q <= bus.awaddr;
    if (w_hs) begin
      w_data_q <= bus.wdata;
      w_strb_q <= bus.wstrb;
    end
  end

  // Write response code, captured on the edge the write fires.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)        bresp_q <= RESP_OKAY;
    else if (do_write) bresp_q <= w_in_range ? RESP_OKAY : RESP_SLVERR;
  end

  // Register file with per-byte strobes; out-of-range writes are dropped.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (do_write && w_in_range) begin
      for (int k = 0; k < 4; k++)
        if (w_strb_eff[k]) regs[w_idx][8*k +: 8] <= w_data_eff[8*k +: 8];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[32*g +: 32] = regs[g];
  end

  // Read FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_state_nx;
  end

  // Read FSM next state: one outstanding read, released by rready.
  always_comb begin
    r_state_nx = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_state_nx = R_DATA;
      R_DATA: if (bus.rready) r_state_nx = R_IDLE;
    endcase
  end

  // Read FSM outputs.
  always_comb begin
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    if (!areset) begin
      case (r_state)
        R_IDLE: bus.arready = 1'b1;
        R_DATA: bus.rvalid  = 1'b1;
      endcase
    end
  end
  assign bus.rdata = rdata_q;
  assign bus.rresp = rresp_q;

  // Read capture samples the pre-edge register value, so a same-edge write is not seen.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= r_in_range ? regs[r_idx] : 32'h0;
      rresp_q <= r_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end
endmodule
